// File: rtl/up_counter_pkg.sv
// Shared types for the up_counter_mod block.
//   state_e : controller states (StIdle, StRun, StDone)
//   StateW  : encoded state width
// StDone is only reachable when UP_COUNTER_SAT_EN is defined.
package up_counter_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/up_counter_mod_if.sv
// Control/status bundle for up_counter_mod.
//   master modport: drives start/stop/clear/load/load_val/limit, observes the status outputs
//   slave  modport: the counter side (inputs above, outputs count/running/wrap/done)
// N is the counter width and must match the counter's N.
interface up_counter_mod_if #(
  parameter int unsigned N = 4
) ();

  logic         start;
  logic         stop;
  logic         clear;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] limit;
  logic [N-1:0] count;
  logic         running;
  logic         wrap;
  logic         done;

  modport master (
    output start, stop, clear, load, load_val, limit,
    input  count, running, wrap, done
  );

  modport slave (
    input  start, stop, clear, load, load_val, limit,
    output count, running, wrap, done
  );

endinterface

// File: rtl/up_counter_tc_cmp.sv
// Terminal-count detector for up_counter_mod.
//   count_i : current registered count
//   limit_i : terminal value, sampled every cycle
//   tc_o    : count has reached the terminal value
// A zero limit is decoded explicitly: once the count is at zero it sits on the
// terminal value every cycle, which is what holds it at 0 with a continuous wrap.
module up_counter_tc_cmp #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] count_i,
  input  logic [N-1:0] limit_i,
  output logic         tc_o
);

  logic count_eq_limit;
  logic limit_zero;
  logic count_zero;

  always_comb begin
    count_eq_limit = (count_i == limit_i);
    limit_zero     = (limit_i == '0);
    count_zero     = (count_i == '0);
    tc_o           = count_eq_limit | (limit_zero & count_zero);
  end

endmodule

// File: rtl/up_counter_mod.sv
// Start/stop up-counter with programmable terminal value.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : up_counter_mod_if.slave (start/stop/clear/load/load_val/limit in;
//             count/running/wrap/done out, all registered or decoded from flops)
// Per-cycle priority: clear > load > stop > start > increment.
// Build option UP_COUNTER_SAT_EN: saturate at the terminal value and enter DONE
// instead of rolling over with a wrap pulse. Undefined (default): wrap build, done tied 0.
module up_counter_mod
  import up_counter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  up_counter_mod_if.slave     bus
);

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         tc;

  up_counter_tc_cmp #(
    .N (N)
  ) u_tc_cmp (
    .count_i (count_q),
    .limit_i (bus.limit),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;

    if (bus.clear) begin
      count_d = '0;
      state_d = StIdle;
    end else if (bus.load) begin
      count_d = bus.load_val;
`ifdef UP_COUNTER_SAT_EN
      if (state_q == StDone) begin
        state_d = StIdle;
      end
`endif
    end else if (bus.stop && (state_q == StRun)) begin
      state_d = StIdle;
    end else if (bus.start && (state_q == StIdle)) begin
      // Count is left alone this cycle; first increment happens next cycle.
      state_d = StRun;
`ifdef UP_COUNTER_SAT_EN
    end else if (bus.start && (state_q == StDone)) begin
      count_d = '0;
      state_d = StRun;
`endif
    end else if (state_q == StRun) begin
      if (tc) begin
`ifdef UP_COUNTER_SAT_EN
        state_d = StDone;
`else
        count_d = '0;
        wrap_d  = 1'b1;
`endif
      end else begin
        // Also covers count > limit: free-run through all-ones to 0, no wrap pulse.
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    bus.count   = count_q;
    bus.running = (state_q == StRun);
    bus.wrap    = wrap_q;
`ifdef UP_COUNTER_SAT_EN
    bus.done    = (state_q == StDone);
`else
    bus.done    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_up_counter_mod.sv
// Self-checking bench for up_counter_mod (N=4). Works for both builds; the
// saturating scenarios are selected by UP_COUNTER_SAT_EN.
module tb_up_counter_mod;

  localparam int unsigned N = 4;
  localparam int Modulus = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  up_counter_mod_if #(.N(N)) bus ();

  up_counter_mod #(
    .N (N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int cur_lim = 5;

  function automatic void chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Behavioural model: integer count, run/done flags.
  int m_cnt  = 0;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  bit m_wrap = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= 0;
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_wrap <= 1'b0;
    end else begin
      m_wrap <= 1'b0;
      if (bus.clear) begin
        m_cnt  <= 0;
        m_run  <= 1'b0;
        m_done <= 1'b0;
      end else if (bus.load) begin
        m_cnt  <= int'(bus.load_val);
        m_done <= 1'b0;
      end else if (bus.stop && m_run) begin
        m_run <= 1'b0;
      end else if (bus.start && !m_run) begin
        m_run <= 1'b1;
        if (m_done) begin
          m_cnt  <= 0;
          m_done <= 1'b0;
        end
      end else if (m_run) begin
        if (m_cnt == int'(bus.limit)) begin
`ifdef UP_COUNTER_SAT_EN
          m_run  <= 1'b0;
          m_done <= 1'b1;
`else
          m_cnt  <= 0;
          m_wrap <= 1'b1;
`endif
        end else begin
          m_cnt <= (m_cnt + 1) % Modulus;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", int'(bus.count), m_cnt);
      chk("model_running", int'(bus.running), int'(m_run));
      chk("model_wrap", int'(bus.wrap), int'(m_wrap));
      chk("model_done", int'(bus.done), int'(m_done));
    end
  end

  // One clock of stimulus; returns 1 time unit after the active edge.
  task automatic drive(input bit st, input bit sp, input bit cl, input bit ld, input int lv);
    bus.start    = st;
    bus.stop     = sp;
    bus.clear    = cl;
    bus.load     = ld;
    bus.load_val = lv[N-1:0];
    bus.limit    = cur_lim[N-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c[8];
    int exp_w[8];
    int seq_c[5];
    int seq_w[5];

    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.limit = 4'd5;
    #2 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    chk("rst_done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    chk("idle_no_count", int'(bus.count), 0);

    // Limit 5 from a running start.
    cur_lim = 5;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("start_count", int'(bus.count), 0);
    chk("start_running", int'(bus.running), 1);
`ifndef UP_COUNTER_SAT_EN
    exp_c = '{0, 1, 2, 3, 4, 5, 0, 1};
    exp_w = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 1; i < 8; i++) begin
      idle(1);
      chk($sformatf("lim5_count[%0d]", i), int'(bus.count), exp_c[i]);
      chk($sformatf("lim5_wrap[%0d]", i), int'(bus.wrap), exp_w[i]);
    end
`else
    idle(7);
    chk("sat5_count", int'(bus.count), 5);
    chk("sat5_done", int'(bus.done), 1);
`endif
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("stop_running", int'(bus.running), 0);
    idle(2);

    // load+stop+start together, then clear+load together.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9);
    chk("lss_idle_count", int'(bus.count), 9);
    chk("lss_idle_running", int'(bus.running), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("lss_start_running", int'(bus.running), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9);
    chk("lss_run_count", int'(bus.count), 9);
    chk("lss_run_running", int'(bus.running), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9);
    chk("clrld_count", int'(bus.count), 0);
    chk("clrld_running", int'(bus.running), 0);

    // count above limit runs through 15 -> 0 with no wrap pulse.
    cur_lim = 2;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 14);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("over_start_count", int'(bus.count), 14);
`ifndef UP_COUNTER_SAT_EN
    seq_c = '{15, 0, 1, 2, 0};
    seq_w = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk($sformatf("over_count[%0d]", i), int'(bus.count), seq_c[i]);
      chk($sformatf("over_wrap[%0d]", i), int'(bus.wrap), seq_w[i]);
    end
`else
    idle(6);
    chk("over_sat_count", int'(bus.count), 2);
    chk("over_sat_done", int'(bus.done), 1);
`endif
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Zero limit.
    cur_lim = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk($sformatf("lim0_count[%0d]", i), int'(bus.count), 0);
`ifndef UP_COUNTER_SAT_EN
      chk($sformatf("lim0_wrap[%0d]", i), int'(bus.wrap), 1);
`else
      chk($sformatf("lim0_done[%0d]", i), int'(bus.done), 1);
`endif
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Reset between edges while running at 7.
    cur_lim = 15;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(7);
    chk("pre_rst_count", int'(bus.count), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_running", int'(bus.running), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(3);
    chk("post_rst_count", int'(bus.count), 0);
    chk("post_rst_running", int'(bus.running), 0);

`ifdef UP_COUNTER_SAT_EN
    // Saturate at 3, then restart from DONE.
    cur_lim = 3;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    chk("sat3_count_run", int'(bus.count), 3);
    chk("sat3_running_run", int'(bus.running), 1);
    idle(1);
    chk("sat3_count", int'(bus.count), 3);
    chk("sat3_done", int'(bus.done), 1);
    chk("sat3_running", int'(bus.running), 0);
    chk("sat3_wrap", int'(bus.wrap), 0);
    idle(2);
    chk("sat3_hold", int'(bus.count), 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("sat3_restart_count", int'(bus.count), 0);
    chk("sat3_restart_done", int'(bus.done), 0);
    chk("sat3_restart_running", int'(bus.running), 1);
    idle(5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("sat3_load_done", int'(bus.done), 0);
    chk("sat3_load_running", int'(bus.running), 0);
`else
    chk("wrapbuild_done", int'(bus.done), 0);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
